// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status into the sequencer, stall/flush controls and
// performance counters back out to the pipeline registers.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             icache_stall;
  logic             dcache_stall;
  logic [4:0]       x_rs1;
  logic [4:0]       x_rs2;
  logic             x_uses_rs1;
  logic             x_uses_rs2;
  logic             x_redirect;
  logic [4:0]       m_rd;
  logic             m_is_load;
  logic             m_valid;

  logic             pc_stall;
  logic             pc_sel_redirect;
  logic             fx_stall;
  logic             fx_flush;
  logic             xm_stall;
  logic             xm_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;

  // Sequencer side.
  modport master (
    input  icache_stall, dcache_stall, x_rs1, x_rs2, x_uses_rs1, x_uses_rs2, x_redirect,
           m_rd, m_is_load, m_valid,
    output pc_stall, pc_sel_redirect, fx_stall, fx_flush, xm_stall, xm_bubble,
           stall_cycles, redirect_count
  );

  // Pipeline side.
  modport slave (
    output icache_stall, dcache_stall, x_rs1, x_rs2, x_uses_rs1, x_uses_rs2, x_redirect,
           m_rd, m_is_load, m_valid,
    input  pc_stall, pc_sel_redirect, fx_stall, fx_flush, xm_stall, xm_bubble,
           stall_cycles, redirect_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the F -> X -> M/WB pipeline. Control outputs are combinational
// from the current state and inputs; only the FSM, its counters and the perf counters are flopped.
module hazard_ctrl #(
  parameter int unsigned LU_BUBBLES    = 1,
  parameter int unsigned RST_FLUSH_CYC = 2,
  parameter int unsigned CNT_W         = 32
) (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_if.master hif
);

  typedef enum logic [1:0] {
    StRstFlush,
    StRun,
    StLuWait,
    StMemFreeze
  } state_e;

  localparam logic [1:0] LuReload = 2'(LU_BUBBLES - 1);
  localparam logic [2:0] RfReload = 3'(RST_FLUSH_CYC);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           eff_state;
  logic [1:0]       bub_cnt_q, bub_cnt_d;
  logic [2:0]       rf_cnt_q, rf_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

  logic rs1_hit, rs2_hit, lu;
  logic pc_stall, pc_sel_redirect, fx_stall, fx_flush, xm_stall, xm_bubble;

  always_comb begin
    rs1_hit = hif.x_uses_rs1 && (hif.x_rs1 == hif.m_rd);
    rs2_hit = hif.x_uses_rs2 && (hif.x_rs2 == hif.m_rd);
    lu      = hif.m_valid && hif.m_is_load && (hif.m_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

  // Releasing a memory freeze resumes the saved state within the same cycle.
  always_comb begin
    eff_state = state_q;
    if (state_q == StMemFreeze && !hif.dcache_stall) begin
      eff_state = ret_q;
    end
  end

  always_comb begin
    state_d         = eff_state;
    ret_d           = ret_q;
    bub_cnt_d       = bub_cnt_q;
    rf_cnt_d        = rf_cnt_q;
    pc_stall        = 1'b0;
    pc_sel_redirect = 1'b0;
    fx_stall        = 1'b0;
    fx_flush        = 1'b0;
    xm_stall        = 1'b0;
    xm_bubble       = 1'b0;

    unique case (eff_state)
      StRstFlush: begin
        pc_stall  = 1'b1;
        fx_flush  = 1'b1;
        xm_bubble = 1'b1;
        rf_cnt_d  = rf_cnt_q - 3'd1;
        if (rf_cnt_q == 3'd1) begin
          state_d = StRun;
        end
      end
      StMemFreeze: begin
        pc_stall = 1'b1;
        fx_stall = 1'b1;
        xm_stall = 1'b1;
      end
      StLuWait: begin
        if (hif.dcache_stall) begin
          pc_stall = 1'b1;
          fx_stall = 1'b1;
          xm_stall = 1'b1;
          state_d  = StMemFreeze;
          ret_d    = StLuWait;
        end else begin
          // X is held here, so a pending redirect waits until RUN.
          pc_stall  = 1'b1;
          fx_stall  = 1'b1;
          xm_bubble = 1'b1;
          bub_cnt_d = bub_cnt_q - 2'd1;
          if (bub_cnt_q == 2'd1) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (hif.dcache_stall) begin
          pc_stall = 1'b1;
          fx_stall = 1'b1;
          xm_stall = 1'b1;
          state_d  = StMemFreeze;
          ret_d    = StRun;
        end else if (lu) begin
          pc_stall  = 1'b1;
          fx_stall  = 1'b1;
          xm_bubble = 1'b1;
          bub_cnt_d = LuReload;
          state_d   = (LU_BUBBLES > 1) ? StLuWait : StRun;
        end else if (hif.x_redirect) begin
          // Redirect overrides a pending fetch wait.
          pc_sel_redirect = 1'b1;
          fx_flush        = 1'b1;
        end else if (hif.icache_stall) begin
          pc_stall = 1'b1;
          fx_flush = 1'b1;
        end
      end
      default: begin
        state_d = StRstFlush;
      end
    endcase

    if (reset) begin
      pc_stall        = 1'b1;
      pc_sel_redirect = 1'b0;
      fx_stall        = 1'b0;
      fx_flush        = 1'b1;
      xm_stall        = 1'b0;
      xm_bubble       = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (pc_stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (pc_sel_redirect && !(&redirect_count_q)) begin
      redirect_count_d = redirect_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StRstFlush;
      ret_q            <= StRun;
      rf_cnt_q         <= RfReload;
      bub_cnt_q        <= 2'd0;
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      ret_q            <= ret_d;
      rf_cnt_q         <= rf_cnt_d;
      bub_cnt_q        <= bub_cnt_d;
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign hif.pc_stall        = pc_stall;
  assign hif.pc_sel_redirect = pc_sel_redirect;
  assign hif.fx_stall        = fx_stall;
  assign hif.fx_flush        = fx_flush;
  assign hif.xm_stall        = xm_stall;
  assign hif.xm_bubble       = xm_bubble;
  assign hif.stall_cycles    = stall_cycles_q;
  assign hif.redirect_count  = redirect_count_q;

  a_fx_excl: assert property (@(posedge clk) !(fx_stall && fx_flush));
  a_xm_excl: assert property (@(posedge clk) !(xm_stall && xm_bubble));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl, checked against a priority-rule reference model that tracks
// only "flush cycles left" and "bubbles still owed" rather than FSM states.
module tb_hazard_ctrl;

  localparam int unsigned LUB  = 2;
  localparam int unsigned RFC  = 2;
  localparam int unsigned CW   = 6;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk;
  logic reset;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(
    .LU_BUBBLES   (LUB),
    .RST_FLUSH_CYC(RFC),
    .CNT_W        (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hif  (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  int         rf_left;
  int         bub_left;
  int         stall_m;
  int         redir_m;
  logic [5:0] exp_o;  // {pc_stall, pc_sel_redirect, fx_stall, fx_flush, xm_stall, xm_bubble}

  function automatic bit load_use_hit();
    bit hit1, hit2;
    hit1 = hif.x_uses_rs1 && (hif.x_rs1 == hif.m_rd);
    hit2 = hif.x_uses_rs2 && (hif.x_rs2 == hif.m_rd);
    return hif.m_valid && hif.m_is_load && (hif.m_rd != 0) && (hit1 || hit2);
  endfunction

  task automatic model_eval();
    if (reset || rf_left > 0)                exp_o = 6'b100101;
    else if (hif.dcache_stall)               exp_o = 6'b101010;
    else if (bub_left > 0 || load_use_hit()) exp_o = 6'b101001;
    else if (hif.x_redirect)                 exp_o = 6'b010100;
    else if (hif.icache_stall)               exp_o = 6'b100100;
    else                                     exp_o = 6'b000000;
  endtask

  task automatic model_clock();
    if (reset) begin
      rf_left  = RFC;
      bub_left = 0;
      stall_m  = 0;
      redir_m  = 0;
      return;
    end
    model_eval();
    if (exp_o[5] && stall_m < CMAX) stall_m++;
    if (exp_o[4] && redir_m < CMAX) redir_m++;
    if (rf_left > 0)               rf_left--;
    else if (hif.dcache_stall)     rf_left = rf_left;
    else if (bub_left > 0)         bub_left--;
    else if (load_use_hit())       bub_left = LUB - 1;
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    check_eq("ctrl", 32'({hif.pc_stall, hif.pc_sel_redirect, hif.fx_stall, hif.fx_flush,
                          hif.xm_stall, hif.xm_bubble}), 32'(exp_o));
    check_eq("stall_cycles", 32'(hif.stall_cycles), 32'(stall_m));
    check_eq("redirect_count", 32'(hif.redirect_count), 32'(redir_m));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    hif.icache_stall = 1'b0;
    hif.dcache_stall = 1'b0;
    hif.x_rs1        = 5'd0;
    hif.x_rs2        = 5'd0;
    hif.x_uses_rs1   = 1'b0;
    hif.x_uses_rs2   = 1'b0;
    hif.x_redirect   = 1'b0;
    hif.m_rd         = 5'd0;
    hif.m_is_load    = 1'b0;
    hif.m_valid      = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    hif.m_valid    = 1'b1;
    hif.m_is_load  = 1'b1;
    hif.m_rd       = rd;
    hif.x_uses_rs2 = 1'b1;
    hif.x_rs2      = rd;
  endtask

  task automatic rand_inputs(input int dc_pct, input int red_pct, input bit allow_reset);
    hif.icache_stall = ($urandom_range(0, 99) < 25);
    hif.dcache_stall = ($urandom_range(0, 99) < dc_pct);
    hif.x_rs1        = 5'($urandom_range(0, 3));
    hif.x_rs2        = 5'($urandom_range(0, 3));
    hif.x_uses_rs1   = 1'($urandom);
    hif.x_uses_rs2   = 1'($urandom);
    hif.x_redirect   = ($urandom_range(0, 99) < red_pct);
    hif.m_rd         = 5'($urandom_range(0, 3));
    hif.m_is_load    = 1'($urandom);
    hif.m_valid      = ($urandom_range(0, 99) < 70);
    reset            = allow_reset && ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    rf_left  = 0;
    bub_left = 0;
    stall_m  = 0;
    redir_m  = 0;
    exp_o    = '0;
    reset    = 1'b1;
    idle_inputs();

    // Reset held 3 cycles, then the post-reset flush.
    @(posedge clk);
    model_clock();
    #1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    check_eq("rst_stall_cnt", 32'(hif.stall_cycles), 32'd2);
    check_eq("rst_run_pc_stall", 32'(hif.pc_stall), 32'd0);

    // Load-use hazard, then the same inputs with rd = x0.
    set_load_use(5'd5);
    step();
    step();
    idle_inputs();
    step();
    set_load_use(5'd0);
    step();
    idle_inputs();

    // Four cycles of data-cache wait from RUN.
    hif.dcache_stall = 1'b1;
    repeat (4) step();
    hif.dcache_stall = 1'b0;
    step();

    // Data-cache wait landing in LU_WAIT with one bubble left.
    set_load_use(5'd7);
    step();
    idle_inputs();
    hif.dcache_stall = 1'b1;
    repeat (3) step();
    hif.dcache_stall = 1'b0;
    step();
    step();

    // Redirect overriding a fetch wait.
    hif.x_redirect   = 1'b1;
    hif.icache_stall = 1'b1;
    step();
    idle_inputs();

    // Redirect held across a data-cache wait: accepted once on release.
    hif.x_redirect   = 1'b1;
    hif.dcache_stall = 1'b1;
    repeat (3) step();
    hif.dcache_stall = 1'b0;
    step();
    idle_inputs();
    step();

    // Random traffic, including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs((i < 700) ? 15 : 35, 20, 1'b1);
      step();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (4) step();

    // Drive both counters into saturation.
    hif.icache_stall = 1'b1;
    repeat (80) step();
    hif.icache_stall = 1'b0;
    hif.x_redirect   = 1'b1;
    repeat (80) step();
    idle_inputs();
    step();
    check_eq("stall_sat", 32'(hif.stall_cycles), 32'(CMAX));
    check_eq("redirect_sat", 32'(hif.redirect_count), 32'(CMAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 3-stage pipeline (F -> X -> M/WB).
- Drives the hold and NOP-inject controls of the PC register, the F/X stage register and the X/M stage register.
- Resolves load-use hazards, data-cache and instruction-cache waits, and control redirects, and flushes the pipeline after reset.
- Exposes saturating performance counters for stall cycles and redirects.

Parameters:
- LU_BUBBLES, 1, number of bubbles inserted on a load-use hazard (legal 1..3).
- RST_FLUSH_CYC, 2, cycles of forced NOP injection after reset deasserts (legal 1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- icache_stall  in  1  fetch not ready this cycle.
- dcache_stall  in  1  M-stage memory access not complete.
- x_rs1  in  5  rs1 of the instruction in X.
- x_rs2  in  5  rs2 of the instruction in X.
- x_uses_rs1  in  1  X instruction reads rs1.
- x_uses_rs2  in  1  X instruction reads rs2.
- x_redirect  in  1  taken branch or jump resolved in X.
- m_rd  in  5  rd of the instruction in M.
- m_is_load  in  1  M instruction is a load.
- m_valid  in  1  M holds a real instruction (not a NOP).
- pc_stall  out  1  PC register holds its value.
- pc_sel_redirect  out  1  PC loads the redirect target.
- fx_stall  out  1  F/X register holds.
- fx_flush  out  1  F/X register loads INSTR_NOP.
- xm_stall  out  1  X/M register holds.
- xm_bubble  out  1  X/M register loads INSTR_NOP.
- stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating.
- redirect_count  out  CNT_W  accepted redirects, saturating.

Behaviour:
- State machine states:
  - RST_FLUSH
  - RUN
  - LU_WAIT
  - MEM_FREEZE
- Counters:
  - bub_cnt: 2 bits.
  - rf_cnt: 3 bits.
- Reset (reset=1 on a clock edge, in any state):
  - state <= RST_FLUSH, rf_cnt <= RST_FLUSH_CYC, bub_cnt <= 0, both perf counters <= 0.
  - Outputs while reset=1: pc_stall=1, fx_flush=1, xm_bubble=1; all other outputs 0.
- RST_FLUSH:
  - Outputs: pc_stall=1, fx_flush=1, xm_bubble=1.
  - rf_cnt decrements each cycle; on rf_cnt==1 go to RUN.
  - Neither hazard nor redirect evaluation is active in this state.
- Hazard term: lu = m_valid & m_is_load & (m_rd!=0) & ((x_uses_rs1 & x_rs1==m_rd) | (x_uses_rs2 & x_rs2==m_rd)).
- RUN priority, highest first:
  1. dcache_stall: pc_stall=fx_stall=xm_stall=1; next state MEM_FREEZE.
  2. lu: pc_stall=fx_stall=1, xm_bubble=1; bub_cnt <= LU_BUBBLES-1; if LU_BUBBLES>1 go to LU_WAIT, else stay in RUN.
  3. x_redirect: pc_sel_redirect=1, fx_flush=1; redirect_count increments. pc_stall=0 even if icache_stall=1, because the redirect overrides a fetch wait.
  4. icache_stall: pc_stall=1, fx_flush=1.
  5. Otherwise all outputs 0.
- MEM_FREEZE:
  - Same outputs as RUN rule 1 while dcache_stall=1.
  - When dcache_stall=0, return to the saved state (RUN or LU_WAIT) the same cycle with bub_cnt preserved, and evaluate that state's rules combinationally in that cycle.
- LU_WAIT:
  - Outputs: pc_stall=fx_stall=1, xm_bubble=1; bub_cnt decrements.
  - On bub_cnt==1 go to RUN.
  - dcache_stall has priority: the state is frozen and MEM_FREEZE saves LU_WAIT as the return state.
  - x_redirect is ignored, because X is held.
- Simultaneous events:
  - dcache_stall + x_redirect: redirect deferred. X is held, so x_redirect stays high and is taken on release; it is counted only once, when accepted.
  - lu + x_redirect cannot both be real: lu wins.
- Exclusivity: fx_stall and fx_flush are never both 1; xm_stall and xm_bubble are never both 1.
- Perf counters:
  - Both counters saturate at all-ones.
  - stall_cycles counts every post-reset cycle with pc_stall=1, including RST_FLUSH.
- Latency: every control output is combinational from current state and inputs, and is valid in the same cycle. Only state and counters are registered.

Test Plan:
- Reset held 3 cycles then released, RST_FLUSH_CYC=2 -> pc_stall=fx_flush=xm_bubble=1 for 3+2 cycles, RUN on 6th cycle; stall_cycles=2.
- m_valid=1, m_is_load=1, m_rd=5, x_uses_rs2=1, x_rs2=5, LU_BUBBLES=2 -> exactly 2 cycles of pc_stall=fx_stall=xm_bubble=1; m_rd=0 with the same inputs -> no stall.
- dcache_stall high 4 cycles in RUN -> pc/fx/xm stall=1 for 4 cycles, no bubble; stall_cycles +4.
- dcache_stall asserted during LU_WAIT with bub_cnt=1 -> frozen for the stall duration, then 1 remaining bubble, then RUN.
- x_redirect with icache_stall=1 -> pc_sel_redirect=1, pc_stall=0, fx_flush=1; redirect_count +1.
- x_redirect held high during 3 cycles of dcache_stall -> no pc_sel_redirect until release, then a single redirect; redirect_count +1. Preset counter to all-ones -> stays all-ones.
